zap_fetch_fifo: RTL



---
 rtl/zap_fetch_fifo_pkg.sv | 20 ++
 rtl/zap_fetch_fifo_if.sv | 21 ++
 rtl/zap_fetch_fifo_chk.sv | 17 +
 rtl/zap_fifo_mem.sv | 27 ++
 rtl/zap_fetch_fifo.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/zap_fetch_fifo_pkg.sv
// Shared definitions for the fetch decoupling buffer.
// The packed entry layout is defined once here so that the predecode stage can
// import the same field widths and bit ordering.
package zap_fetch_fifo_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int TAKEN_W = 2;
  localparam int ENTRY_W = INSTR_W + 1 + PC_W + PC_W + TAKEN_W;  // 99

  // Entry layout, MSB first: {instr, abort, pc, pc+8, taken}.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               abort;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus_8;
    logic [TAKEN_W-1:0] taken;
  } fetch_entry_t;

endpackage

// File: rtl/zap_fetch_fifo_if.sv
// Write-side bundle from fetch into the buffer. Fetch is the master and
// drives the entry; the buffer is the slave and returns the almost-full stall.
interface zap_fetch_fifo_if;
  logic        valid;
  logic [31:0] instruction;
  logic        instr_abort;
  logic [31:0] pc_ff;
  logic [31:0] pc_plus_8_ff;
  logic [1:0]  taken;
  logic        stall_to_fetch;

  modport master (
    output valid, instruction, instr_abort, pc_ff, pc_plus_8_ff, taken,
    input  stall_to_fetch
  );

  modport slave (
    input  valid, instruction, instr_abort, pc_ff, pc_plus_8_ff, taken,
    output stall_to_fetch
  );
endinterface

// File: rtl/zap_fetch_fifo_chk.sv
// Protocol checker for the fetch buffer: fetch must never push into a full
// buffer unless the same cycle also drains an entry.
module zap_fetch_fifo_chk (
  input logic i_clk,
  input logic i_reset_n,
  input logic i_flush,
  input logic i_wr,
  input logic i_pop,
  input logic i_full
);

  // An unbacked write at full occupancy is silently dropped by the buffer.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(i_wr && i_full && !i_pop && !i_flush))
    else $error("zap_fetch_fifo: write dropped, storage full");

endmodule

// File: rtl/zap_fifo_mem.sv
// Entry storage for the fetch buffer: DEPTH words, one synchronous write port
// and one asynchronous read port. Occupancy is tracked by the owner, so the
// array itself needs no reset.
module zap_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 99
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Capture the incoming entry at the write pointer.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/zap_fetch_fifo.sv
// Decoupling buffer between fetch and predecode. Entries are kept in order in
// a small circular store behind a registered output stage; an empty store lets
// a write bypass straight into the output register. An aborted fetch locks the
// buffer against further writes until the next pipeline clear.
module zap_fetch_fifo
  import zap_fetch_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_clear_from_writeback,
  input  logic                  i_data_stall,
  input  logic                  i_clear_from_alu,
  input  logic                  i_stall_from_shifter,
  input  logic                  i_stall_from_issue,
  input  logic                  i_stall_from_decode,
  input  logic                  i_clear_from_decode,
  zap_fetch_fifo_if.slave       fetch_if,
  output logic                  o_valid,
  output logic [INSTR_W-1:0]    o_instruction,
  output logic                  o_instr_abort,
  output logic [PC_W-1:0]       o_pc_ff,
  output logic [PC_W-1:0]       o_pc_plus_8_ff,
  output logic [TAKEN_W-1:0]    o_taken
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             lock_q, lock_d;
  logic             valid_q, valid_d;
  fetch_entry_t     out_q, out_d;

  logic             flush_s;
  logic             stall_s;
  logic             wr_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             bypass_s;
  logic             push_s;
  logic             accept_s;
  logic             mem_we_s;
  fetch_entry_t     in_entry_s;
  fetch_entry_t     head_entry_s;

  assign in_entry_s = '{
    instr:     fetch_if.instruction,
    abort:     fetch_if.instr_abort,
    pc:        fetch_if.pc_ff,
    pc_plus_8: fetch_if.pc_plus_8_ff,
    taken:     fetch_if.taken
  };

  zap_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (mem_we_s),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (in_entry_s),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (head_entry_s)
  );

  // Decide this cycle's push/pop/bypass and the next buffer state.
  always_comb begin
    flush_s  = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;
    stall_s  = i_data_stall | i_stall_from_shifter | i_stall_from_issue |
               i_stall_from_decode;
    wr_s     = fetch_if.valid & ~lock_q;
    empty_s  = (count_q == {CNT_W{1'b0}});
    full_s   = (count_q == CNT_W'(DEPTH));
    pop_s    = ~stall_s & ~empty_s;
    bypass_s = ~stall_s & empty_s & wr_s;
    push_s   = wr_s & ~bypass_s & (~full_s | pop_s);
    accept_s = bypass_s | push_s;
    mem_we_s = push_s & ~flush_s;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lock_d   = lock_q;
    valid_d  = valid_q;
    out_d    = out_q;

    if (flush_s) begin
      // A clear drops everything, including any write arriving this cycle.
      wr_ptr_d    = {PTR_W{1'b0}};
      rd_ptr_d    = {PTR_W{1'b0}};
      count_d     = {CNT_W{1'b0}};
      lock_d      = 1'b0;
      valid_d     = 1'b0;
      out_d.abort = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // Fetch sleeps after an abort; further writes are ignored until a clear.
      lock_d = lock_q | (accept_s & fetch_if.instr_abort);

      if (stall_s) begin
        valid_d = valid_q;
        out_d   = out_q;
      end else if (pop_s) begin
        valid_d = 1'b1;
        out_d   = head_entry_s;
      end else if (bypass_s) begin
        valid_d = 1'b1;
        out_d   = in_entry_s;
      end else begin
        valid_d = 1'b0;
        out_d   = out_q;
      end
    end
  end

  // Buffer state and output register, cleared asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      lock_q   <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lock_q   <= lock_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
    end
  end

  // One slot stays free for the write already in flight from fetch.
  assign fetch_if.stall_to_fetch = (count_q >= CNT_W'(DEPTH - 1)) | lock_q;

  assign o_valid        = valid_q;
  assign o_instruction  = out_q.instr;
  assign o_instr_abort  = out_q.abort;
  assign o_pc_ff        = out_q.pc;
  assign o_pc_plus_8_ff = out_q.pc_plus_8;
  assign o_taken        = out_q.taken;

  zap_fetch_fifo_chk u_chk (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_flush   (flush_s),
    .i_wr      (wr_s),
    .i_pop     (pop_s),
    .i_full    (full_s)
  );

endmodule
